// File: rtl/times_table_writer.sv
// Times-table fill engine: walks every operand pair {a,b}, forms a*b with a
// W-cycle shift-add multiplier and writes each product to address {a,b}.
module times_table_writer #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mem_ready,
    output logic           wr_en,
    output logic [2*W-1:0] wr_addr,
    output logic [2*W-1:0] wr_data,
    output logic           busy,
    output logic           done
);

    // Write handshake: an entry transfers on a rising edge where wr_en and
    // mem_ready are both high; while wr_en=1 and mem_ready=0 the engine holds
    // wr_en, wr_addr and wr_data unchanged for as long as it takes.

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  step;

    logic           begin_fill;
    logic           accept;
    logic           last_entry;
    logic [2*W-1:0] partial;

    assign last_entry = &{a, b};
    assign partial    = a[step] ? ({{W{1'b0}}, b} << step) : '0;

    assign wr_addr = {a, b};
    assign wr_data = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        begin_fill = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    begin_fill = 1'b1;
                    state_nxt  = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (step == LAST_STEP) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (mem_ready) begin
                    accept    = 1'b1;
                    state_nxt = last_entry ? DONE : MUL;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    begin_fill = 1'b1;
                    state_nxt  = MUL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand walk (b inner, a outer) and shift-add accumulation. The last
    // entry leaves {a,b} at all ones so DONE keeps showing the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            b    <= '0;
            acc  <= '0;
            step <= '0;
        end else if (begin_fill) begin
            a    <= '0;
            b    <= '0;
            acc  <= '0;
            step <= '0;
        end else if (state == MUL) begin
            acc  <= acc + partial;
            step <= (step == LAST_STEP) ? '0 : step + CW'(1);
        end else if (accept && !last_entry) begin
            {a, b} <= {a, b} + (2*W)'(1);
            acc    <= '0;
            step   <= '0;
        end
    end

endmodule
